umi_switch_q: RTL and testbench

- Next-generation UMI crossbar: N UMI request inputs, M UMI outputs.
- Routing decoded internally from a parametrised dstaddr field; no pre-decoded N*M valid vector.
- Per output: arbiter with round-robin or fixed-priority mode, grant lock across multi-beat transactions until EOM, synchronous output queue of parametrised depth.
- Sits between host-side UMI agents and device-side UMI endpoints.

---
 rtl/umi_switch_pkg.sv | 29 ++
 rtl/umi_switch_if.sv | 19 +
 rtl/umi_switch_port.sv | 154 +++++++++++++++
 rtl/umi_switch_q.sv | 104 ++++++++++
 tb/tb_umi_switch_q.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/umi_switch_pkg.sv
// Shared constants and beat layout for the UMI crossbar.
`ifndef UMI_SWITCH_DW
`define UMI_SWITCH_DW 256
`endif
`ifndef UMI_SWITCH_AW
`define UMI_SWITCH_AW 64
`endif
`ifndef UMI_SWITCH_CW
`define UMI_SWITCH_CW 32
`endif

package umi_switch_pkg;

    localparam int unsigned UMI_DW      = `UMI_SWITCH_DW;
    localparam int unsigned UMI_AW      = `UMI_SWITCH_AW;
    localparam int unsigned UMI_CW      = `UMI_SWITCH_CW;
    localparam int unsigned UMI_EOM_BIT = 22;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    typedef struct packed {
        logic [`UMI_SWITCH_CW-1:0] cmd;
        logic [`UMI_SWITCH_AW-1:0] dstaddr;
        logic [`UMI_SWITCH_AW-1:0] srcaddr;
        logic [`UMI_SWITCH_DW-1:0] data;
    } umi_beat_t;

endpackage

// File: rtl/umi_switch_if.sv
// Bundle of P parallel UMI channels; master drives valid/payload, slave drives ready.
interface umi_switch_if #(
    parameter int unsigned P  = 4,
    parameter int unsigned CW = umi_switch_pkg::UMI_CW,
    parameter int unsigned AW = umi_switch_pkg::UMI_AW,
    parameter int unsigned DW = umi_switch_pkg::UMI_DW
);

    logic [P-1:0]    valid;
    logic [P*CW-1:0] cmd;
    logic [P*AW-1:0] dstaddr;
    logic [P*AW-1:0] srcaddr;
    logic [P*DW-1:0] data;
    logic [P-1:0]    ready;

    modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
    modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);

endinterface

// File: rtl/umi_switch_port.sv
// One crossbar output: arbiter with EOM lock, followed by a DEPTH-entry synchronous FIFO.
module umi_switch_port
    import umi_switch_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = 256,
    parameter int unsigned AW    = 64,
    parameter int unsigned CW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         arbmode_i,
    input  logic [N-1:0]                 req_i,
    input  logic [N*CW-1:0]              in_cmd_i,
    input  logic [N*AW-1:0]              in_dstaddr_i,
    input  logic [N*AW-1:0]              in_srcaddr_i,
    input  logic [N*DW-1:0]              in_data_i,
    output logic [N-1:0]                 in_ready_o,
    output logic                         out_valid_o,
    output logic [CW-1:0]                out_cmd_o,
    output logic [AW-1:0]                out_dstaddr_o,
    output logic [AW-1:0]                out_srcaddr_o,
    output logic [DW-1:0]                out_data_o,
    input  logic                         out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   out_level_o
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dstaddr;
        logic [AW-1:0] srcaddr;
        logic [DW-1:0] data;
    } beat_t;

    state_e        st_q, st_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] win;
    logic          win_vld;
    beat_t         in_beat;
    logic          win_eom;
    logic          space, push, pop;
    beat_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;

    // Descending scans: the last hit is the first requester in priority order.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        if (st_q == StLocked) begin
            win     = owner_q;
            win_vld = req_i[owner_q];
        end else if (arbmode_i == ARB_FIXED) begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                if (req_i[k]) begin
                    win     = IW'(k);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr_q) + k) % int'(N);
                if (req_i[idx]) begin
                    win     = IW'(idx);
                    win_vld = 1'b1;
                end
            end
        end
    end

    assign in_beat = '{cmd:     in_cmd_i[int'(win)*CW +: CW],
                       dstaddr: in_dstaddr_i[int'(win)*AW +: AW],
                       srcaddr: in_srcaddr_i[int'(win)*AW +: AW],
                       data:    in_data_i[int'(win)*DW +: DW]};
    assign win_eom = in_beat.cmd[UMI_EOM_BIT];

    // A full queue still accepts when the head leaves in the same cycle.
    assign space = (level_q != LW'(DEPTH)) || out_ready_i;
    assign push  = win_vld && space && nreset;
    assign pop   = (level_q != '0) && out_ready_i;

    always_comb begin
        in_ready_o      = '0;
        in_ready_o[win] = push;
    end

    always_comb begin
        st_d     = st_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            if (win_eom) begin
                st_d = StIdle;
                if (arbmode_i == ARB_RR) begin
                    rr_ptr_d = (win == IW'(N - 1)) ? '0 : win + 1'b1;
                end
            end else begin
                st_d    = StLocked;
                owner_d = win;
            end
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            st_q     <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            st_q     <= st_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            level_q  <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_beat;
        end
    end

    assign out_valid_o   = (level_q != '0);
    assign out_cmd_o     = mem_q[rd_ptr_q].cmd;
    assign out_dstaddr_o = mem_q[rd_ptr_q].dstaddr;
    assign out_srcaddr_o = mem_q[rd_ptr_q].srcaddr;
    assign out_data_o    = mem_q[rd_ptr_q].data;
    assign out_level_o   = level_q;

endmodule

// File: rtl/umi_switch_q.sv
// UMI N-to-M crossbar: decodes the routing field, drops unroutable beats, fans out to ports.
module umi_switch_q
    import umi_switch_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned M     = 4,
    parameter int unsigned DW    = UMI_DW,
    parameter int unsigned AW    = UMI_AW,
    parameter int unsigned CW    = UMI_CW,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RLSB  = 40,
    parameter int unsigned RW    = 16
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           arbmode,
    umi_switch_if.slave                    umi_in,
    umi_switch_if.master                   umi_out,
    output logic [N-1:0]                   err_route,
    output logic [M*$clog2(DEPTH+1)-1:0]   out_level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [RW-1:0]   dest [N];
    logic [N-1:0]    bad;
    logic [N-1:0]    req [M];
    logic [N-1:0]    port_rdy [M];
    logic [N-1:0]    in_rdy;
    logic [N-1:0]    err_q, err_d;
    logic [M-1:0]    out_valid;
    logic [M*CW-1:0] out_cmd;
    logic [M*AW-1:0] out_dstaddr;
    logic [M*AW-1:0] out_srcaddr;
    logic [M*DW-1:0] out_data;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            dest[i] = umi_in.dstaddr[i*AW+RLSB +: RW];
            bad[i]  = umi_in.valid[i] && (dest[i] >= RW'(M));
        end
        for (int m = 0; m < int'(M); m++) begin
            req[m] = '0;
            for (int i = 0; i < int'(N); i++) begin
                req[m][i] = umi_in.valid[i] && (dest[i] == RW'(m));
            end
        end
    end

    for (genvar m = 0; m < int'(M); m++) begin : g_port
        umi_switch_port #(
            .N     (N),
            .DW    (DW),
            .AW    (AW),
            .CW    (CW),
            .DEPTH (DEPTH)
        ) u_port (
            .clk           (clk),
            .nreset        (nreset),
            .arbmode_i     (arbmode),
            .req_i         (req[m]),
            .in_cmd_i      (umi_in.cmd),
            .in_dstaddr_i  (umi_in.dstaddr),
            .in_srcaddr_i  (umi_in.srcaddr),
            .in_data_i     (umi_in.data),
            .in_ready_o    (port_rdy[m]),
            .out_valid_o   (out_valid[m]),
            .out_cmd_o     (out_cmd[m*CW +: CW]),
            .out_dstaddr_o (out_dstaddr[m*AW +: AW]),
            .out_srcaddr_o (out_srcaddr[m*AW +: AW]),
            .out_data_o    (out_data[m*DW +: DW]),
            .out_ready_i   (umi_out.ready[m]),
            .out_level_o   (out_level[m*LW +: LW])
        );
    end

    // Unroutable beats are swallowed immediately so the source never stalls on them.
    always_comb begin
        in_rdy = bad;
        for (int m = 0; m < int'(M); m++) begin
            in_rdy = in_rdy | port_rdy[m];
        end
        in_rdy = in_rdy & {N{nreset}};
    end

    assign err_d = bad & {N{nreset}};

    always_ff @(posedge clk) begin
        if (!nreset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_route       = err_q;
    assign umi_in.ready    = in_rdy;
    assign umi_out.valid   = out_valid;
    assign umi_out.cmd     = out_cmd;
    assign umi_out.dstaddr = out_dstaddr;
    assign umi_out.srcaddr = out_srcaddr;
    assign umi_out.data    = out_data;

endmodule

// File: tb/tb_umi_switch_q.sv
// Crossbar bench: per-output queue/lock reference model checked every cycle, plus directed cases.
module tb_umi_switch_q;
    import umi_switch_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned M     = 4;
    localparam int unsigned DW    = 256;
    localparam int unsigned AW    = 64;
    localparam int unsigned CW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned RLSB  = 40;
    localparam int unsigned RW    = 16;
    localparam int unsigned LW    = $clog2(DEPTH + 1);
    localparam int unsigned BW    = $bits(umi_beat_t);

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            arbmode = 1'b0;
    logic [N-1:0]    err_route;
    logic [M*LW-1:0] out_level;

    umi_switch_if #(.P(N), .CW(CW), .AW(AW), .DW(DW)) in_if ();
    umi_switch_if #(.P(M), .CW(CW), .AW(AW), .DW(DW)) out_if ();

    umi_switch_q #(
        .N(N), .M(M), .DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH), .RLSB(RLSB), .RW(RW)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .arbmode   (arbmode),
        .umi_in    (in_if),
        .umi_out   (out_if),
        .err_route (err_route),
        .out_level (out_level)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    bit          live = 1'b0;
    umi_beat_t   cur [N];
    logic [N-1:0] vld;
    logic [M-1:0] ordy;
    int          left [N];
    int          gdst [N];

    // Reference model: one ordered queue, one owner and one pointer per output.
    umi_beat_t   mq [M][$];
    int          lock [M];
    int          ptr [M];
    logic [N-1:0] exp_err;
    logic [N-1:0] accepted;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int dest_of(umi_beat_t b);
        return int'(b.dstaddr[RLSB +: RW]);
    endfunction

    function automatic umi_beat_t mk_beat(int dest, bit eom, logic [31:0] seed);
        umi_beat_t b;
        b.cmd                   = seed ^ 32'h1357_9BDF;
        b.cmd[UMI_EOM_BIT]      = eom;
        b.dstaddr               = {seed, ~seed};
        b.dstaddr[RLSB +: RW]   = RW'(dest);
        b.srcaddr               = {~seed, seed ^ 32'h5A5A_0000};
        b.data                  = {8{seed ^ 32'hA5A5_0000}};
        return b;
    endfunction

    function automatic logic [BW-1:0] out_beat(int o);
        return {out_if.cmd[o*CW +: CW], out_if.dstaddr[o*AW +: AW],
                out_if.srcaddr[o*AW +: AW], out_if.data[o*DW +: DW]};
    endfunction

    task automatic drive();
        for (int i = 0; i < int'(N); i++) begin
            in_if.valid[i]              = vld[i];
            in_if.cmd[i*CW +: CW]       = cur[i].cmd;
            in_if.dstaddr[i*AW +: AW]   = cur[i].dstaddr;
            in_if.srcaddr[i*AW +: AW]   = cur[i].srcaddr;
            in_if.data[i*DW +: DW]      = cur[i].data;
        end
        out_if.ready = ordy;
    endtask

    task automatic pre();
        drive();
        #1;
    endtask

    task automatic model_clear();
        for (int o = 0; o < int'(M); o++) begin
            mq[o].delete();
            lock[o] = -1;
            ptr[o]  = 0;
        end
        exp_err  = '0;
        accepted = '0;
    endtask

    // One clock: predict, compare away from the edge, then advance the model at the edge.
    task automatic step();
        int           cand [M];
        bit           sp [M];
        logic [N-1:0] er;
        logic [N-1:0] bad;
        int           i;
        drive();
        #1;
        bad = '0;
        er  = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (vld[k] && dest_of(cur[k]) >= int'(M)) bad[k] = 1'b1;
        end
        for (int o = 0; o < int'(M); o++) begin
            cand[o] = -1;
            sp[o]   = (mq[o].size() < int'(DEPTH)) || ordy[o];
            if (lock[o] >= 0) begin
                if (vld[lock[o]] && dest_of(cur[lock[o]]) == o) cand[o] = lock[o];
            end else begin
                for (int k = 0; k < int'(N); k++) begin
                    i = arbmode ? k : (ptr[o] + k) % int'(N);
                    if (cand[o] < 0 && vld[i] && dest_of(cur[i]) == o) cand[o] = i;
                end
            end
            if (nreset && cand[o] >= 0 && sp[o]) er[cand[o]] = 1'b1;
        end
        if (nreset) er = er | bad;
        if (live) begin
            chk("in_ready", in_if.ready, er);
            chk("err_route", err_route, exp_err);
            for (int o = 0; o < int'(M); o++) begin
                chk($sformatf("out_valid[%0d]", o), out_if.valid[o], mq[o].size() > 0);
                chk($sformatf("out_level[%0d]", o), out_level[o*LW +: LW], mq[o].size());
                if (mq[o].size() > 0) chk($sformatf("out_beat[%0d]", o), out_beat(o), mq[o][0]);
            end
        end
        @(posedge clk);
        accepted = er & vld;
        if (!nreset) begin
            model_clear();
        end else begin
            for (int o = 0; o < int'(M); o++) begin
                if (mq[o].size() > 0 && ordy[o]) void'(mq[o].pop_front());
                if (cand[o] >= 0 && sp[o]) begin
                    mq[o].push_back(cur[cand[o]]);
                    if (cur[cand[o]].cmd[UMI_EOM_BIT]) begin
                        lock[o] = -1;
                        if (arbmode == ARB_RR) ptr[o] = (cand[o] + 1) % int'(N);
                    end else begin
                        lock[o] = cand[o];
                    end
                end
            end
            exp_err = bad;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        vld    = '0;
        step();
        nreset = 1'b1;
        for (int i = 0; i < int'(N); i++) left[i] = 0;
    endtask

    task automatic gen();
        for (int i = 0; i < int'(N); i++) begin
            if (vld[i] && accepted[i]) begin
                left[i]--;
                vld[i] = 1'b0;
                if (left[i] > 0) begin
                    cur[i] = mk_beat(gdst[i], left[i] == 1, $urandom);
                    vld[i] = ($urandom_range(0, 3) != 0);
                end
            end else if (!vld[i]) begin
                if (left[i] > 0) begin
                    vld[i] = ($urandom_range(0, 2) != 0);
                end else if ($urandom_range(0, 2) == 0) begin
                    gdst[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(M, 2*M + 3))
                                                          : int'($urandom_range(0, M - 1));
                    left[i] = int'($urandom_range(1, 4));
                    cur[i]  = mk_beat(gdst[i], left[i] == 1, $urandom);
                    vld[i]  = 1'b1;
                end
            end
        end
    endtask

    initial begin
        umi_beat_t    b, b0, b1, b2;
        logic [N-1:0] rr_seq [3];
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b1000;
        ordy = '1;
        vld  = '0;
        for (int i = 0; i < int'(N); i++) begin
            cur[i]  = mk_beat(0, 1'b1, 32'h0);
            left[i] = 0;
            gdst[i] = 0;
        end
        model_clear();

        // Reset state: first edge unchecked, second cycle checks the cleared outputs.
        nreset = 1'b0;
        step();
        live = 1'b1;
        step();
        nreset = 1'b1;

        // Single EOM beat, input 2 -> output 3, latency 1.
        do_reset();
        b = mk_beat(3, 1'b1, 32'hC0FF_EE02);
        cur[2] = b;
        vld = 4'b0100;
        pre();
        chk("d1_accept", in_if.ready, 4'b0100);
        chk("d1_no_out_yet", out_if.valid, 4'b0000);
        step();
        vld = '0;
        pre();
        chk("d1_valid", out_if.valid, 4'b1000);
        chk("d1_payload", out_beat(3), b);
        chk("d1_level", out_level[3*LW +: LW], 1);
        step();
        pre();
        chk("d1_drained", out_if.valid, 4'b0000);
        chk("d1_level0", out_level, 0);
        step();

        // Round robin among inputs 0, 1, 3 on output 1.
        do_reset();
        arbmode = ARB_RR;
        for (int k = 0; k < 6; k++) begin
            cur[0] = mk_beat(1, 1'b1, $urandom);
            cur[1] = mk_beat(1, 1'b1, $urandom);
            cur[3] = mk_beat(1, 1'b1, $urandom);
            vld = 4'b1011;
            pre();
            chk($sformatf("d2_rr[%0d]", k), in_if.ready, rr_seq[k % 3]);
            step();
        end
        vld = '0;
        step();
        step();

        // Fixed priority: input 0 always wins.
        do_reset();
        arbmode = ARB_FIXED;
        for (int k = 0; k < 4; k++) begin
            cur[0] = mk_beat(1, 1'b1, $urandom);
            cur[1] = mk_beat(1, 1'b1, $urandom);
            cur[3] = mk_beat(1, 1'b1, $urandom);
            vld = 4'b1011;
            pre();
            chk($sformatf("d3_fixed[%0d]", k), in_if.ready, 4'b0001);
            step();
        end
        vld = '0;
        step();
        step();

        // Lock: 4-beat transaction from input 1 holds output 0 against input 0.
        do_reset();
        arbmode = ARB_RR;
        cur[1] = mk_beat(0, 1'b0, 32'h1000_0000);
        vld = 4'b0010;
        pre();
        chk("d4_first", in_if.ready, 4'b0010);
        step();
        for (int k = 1; k < 4; k++) begin
            cur[1] = mk_beat(0, k == 3, 32'h1000_0000 + k);
            cur[0] = mk_beat(0, 1'b1, 32'h0000_0100 + k);
            vld = 4'b0011;
            pre();
            chk($sformatf("d4_locked[%0d]", k), in_if.ready, 4'b0010);
            step();
        end
        vld = 4'b0001;
        pre();
        chk("d4_released", in_if.ready, 4'b0001);
        step();
        vld = '0;
        step();
        step();

        // Back-pressure on output 2: fill to DEPTH, then drain in order.
        do_reset();
        ordy = 4'b1011;
        b0 = mk_beat(2, 1'b1, 32'hB000_0000);
        b1 = mk_beat(2, 1'b1, 32'hB000_0001);
        b2 = mk_beat(2, 1'b1, 32'hB000_0002);
        cur[0] = b0;
        vld = 4'b0001;
        pre();
        chk("d5_push0", in_if.ready, 4'b0001);
        step();
        cur[0] = b1;
        pre();
        chk("d5_push1", in_if.ready, 4'b0001);
        step();
        cur[0] = b2;
        pre();
        chk("d5_full_ready", in_if.ready, 4'b0000);
        chk("d5_full_level", out_level[2*LW +: LW], 2);
        step();
        ordy = 4'b1111;
        pre();
        chk("d5_push_pop_ready", in_if.ready, 4'b0001);
        chk("d5_push_pop_level", out_level[2*LW +: LW], 2);
        chk("d5_head0", out_beat(2), b0);
        step();
        vld = '0;
        pre();
        chk("d5_head1", out_beat(2), b1);
        chk("d5_level_hold", out_level[2*LW +: LW], 2);
        step();
        pre();
        chk("d5_head2", out_beat(2), b2);
        chk("d5_level1", out_level[2*LW +: LW], 1);
        step();
        pre();
        chk("d5_empty", out_if.valid, 4'b0000);
        step();

        // Unroutable destination 7.
        do_reset();
        cur[3] = mk_beat(7, 1'b1, 32'hE770_0003);
        vld = 4'b1000;
        pre();
        chk("d6_accept", in_if.ready, 4'b1000);
        chk("d6_err_before", err_route, 4'b0000);
        step();
        vld = '0;
        pre();
        chk("d6_err_pulse", err_route, 4'b1000);
        chk("d6_no_valid", out_if.valid, 4'b0000);
        step();
        pre();
        chk("d6_err_clear", err_route, 4'b0000);
        chk("d6_still_no_valid", out_if.valid, 4'b0000);
        step();

        // Reset in the middle of a locked transaction.
        do_reset();
        ordy = 4'b1110;
        cur[1] = mk_beat(0, 1'b0, 32'h7700_0001);
        vld = 4'b0010;
        step();
        step();
        nreset = 1'b0;
        pre();
        chk("d7_ready_in_reset", in_if.ready, 4'b0000);
        step();
        nreset = 1'b1;
        vld = '0;
        pre();
        chk("d7_flushed", out_if.valid, 4'b0000);
        chk("d7_level0", out_level, 0);
        ordy = 4'b1111;
        cur[2] = mk_beat(0, 1'b1, 32'h7700_0002);
        vld = 4'b0100;
        pre();
        chk("d7_fresh_accept", in_if.ready, 4'b0100);
        step();
        vld = '0;
        pre();
        chk("d7_fresh_out", out_if.valid, 4'b0001);
        step();

        // Randomized traffic against the model.
        for (int ph = 0; ph < 4; ph++) begin
            do_reset();
            arbmode = ph[0];
            for (int c = 0; c < 1500; c++) begin
                gen();
                for (int o = 0; o < int'(M); o++) begin
                    ordy[o] = (ph < 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
                end
                if ($urandom_range(0, 299) == 0) arbmode = ~arbmode;
                if ($urandom_range(0, 499) == 0) begin
                    nreset = 1'b0;
                    step();
                    nreset = 1'b1;
                    vld = '0;
                    for (int i = 0; i < int'(N); i++) left[i] = 0;
                end else begin
                    step();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
